// File: rtl/fc_layer_trainer.sv
// Training sequencer for one fully-connected layer (owns W/bias; forward, error capture, update). out_valid 1 cycle after accept, ierr_valid 2 cycles after error accept.
// Backpressure: out_valid/ierr_valid hold with stable data until ready; ready outputs depend only on state and wl_valid.
module fc_layer_trainer #(
    parameter int                      WIDTH             = 32,
    parameter int                      INPUT_DIM         = 4,
    parameter int                      OUTPUT_DIM        = 2,
    parameter logic signed [WIDTH-1:0] LEARNING_RATE     = 32'sh0000_1000,
    parameter int                      FIXED_POINT_INDEX = 16,
    parameter int                      CNT_WIDTH         = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INPUT_DIM-1:0][WIDTH-1:0]  in_data,
    input  logic                             train_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUTPUT_DIM-1:0][WIDTH-1:0] out_data,
    input  logic                             err_valid,
    output logic                             err_ready,
    input  logic [OUTPUT_DIM-1:0][WIDTH-1:0] err_data,
    output logic                             ierr_valid,
    input  logic                             ierr_ready,
    output logic [INPUT_DIM-1:0][WIDTH-1:0]  ierr_data,
    input  logic                             wl_valid,
    output logic                             wl_ready,
    input  logic [$clog2(INPUT_DIM+1)-1:0]   wl_row,
    input  logic [$clog2(OUTPUT_DIM)-1:0]    wl_col,
    input  logic [WIDTH-1:0]                 wl_data,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             sample_count
);

    localparam int ROWS = INPUT_DIM + 1;

    typedef enum logic [2:0] {IDLE, FWD, WAIT_ERR, UPDATE, BWD} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] w_q    [ROWS][OUTPUT_DIM];
    logic signed [WIDTH-1:0] w_d    [ROWS][OUTPUT_DIM];
    logic signed [WIDTH-1:0] w_upd  [ROWS][OUTPUT_DIM];
    logic signed [WIDTH-1:0] x_q    [INPUT_DIM];
    logic signed [WIDTH-1:0] x_d    [INPUT_DIM];
    logic signed [WIDTH-1:0] e_q    [OUTPUT_DIM];
    logic signed [WIDTH-1:0] e_d    [OUTPUT_DIM];
    logic signed [WIDTH-1:0] ierr_q [INPUT_DIM];
    logic signed [WIDTH-1:0] ierr_d [INPUT_DIM];
    logic signed [WIDTH-1:0] ierr_calc [INPUT_DIM];
    logic signed [WIDTH-1:0] fwd    [OUTPUT_DIM];
    logic                    tr_q, tr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    wl_hit;

    // Full-precision product rescaled to the fixed-point grid; the arithmetic shift floors.
    function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        return p[FIXED_POINT_INDEX +: WIDTH];
    endfunction

    // Combinational datapath: forward, input error and gradient step all read the current W.
    always_comb begin
        for (int j = 0; j < OUTPUT_DIM; j++) begin
            fwd[j]      = w_q[0][j];
            w_upd[0][j] = w_q[0][j] + fx_mul(LEARNING_RATE, e_q[j]);
            for (int i = 0; i < INPUT_DIM; i++) begin
                fwd[j]        = fwd[j] + fx_mul(x_q[i], w_q[i+1][j]);
                w_upd[i+1][j] = w_q[i+1][j] + fx_mul(LEARNING_RATE, fx_mul(x_q[i], e_q[j]));
            end
        end
        for (int i = 0; i < INPUT_DIM; i++) begin
            ierr_calc[i] = '0;
            for (int j = 0; j < OUTPUT_DIM; j++) begin
                ierr_calc[i] = ierr_calc[i] + fx_mul(w_q[i+1][j], e_q[j]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < OUTPUT_DIM; j++) out_data[j] = fwd[j];
        for (int i = 0; i < INPUT_DIM; i++)  ierr_data[i] = ierr_q[i];
        busy         = (state_q != IDLE);
        sample_count = cnt_q;
        wl_hit       = (32'(wl_row) < ROWS) && (32'(wl_col) < OUTPUT_DIM);
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        x_d        = x_q;
        e_d        = e_q;
        ierr_d     = ierr_q;
        tr_d       = tr_q;
        cnt_d      = cnt_q;
        in_ready   = 1'b0;
        wl_ready   = 1'b0;
        out_valid  = 1'b0;
        err_ready  = 1'b0;
        ierr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                wl_ready = 1'b1;
                in_ready = ~wl_valid;
                if (wl_valid) begin
                    if (wl_hit) w_d[wl_row][wl_col] = wl_data;
                end else if (in_valid) begin
                    for (int i = 0; i < INPUT_DIM; i++) x_d[i] = in_data[i];
                    tr_d    = train_en;
                    state_d = FWD;
                end
            end
            FWD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (tr_q) begin
                        state_d = WAIT_ERR;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            WAIT_ERR: begin
                err_ready = 1'b1;
                if (err_valid) begin
                    for (int j = 0; j < OUTPUT_DIM; j++) e_d[j] = err_data[j];
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                w_d     = w_upd;
                ierr_d  = ierr_calc;
                state_d = BWD;
            end
            BWD: begin
                ierr_valid = 1'b1;
                if (ierr_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tr_q    <= 1'b0;
            cnt_q   <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < OUTPUT_DIM; c++) w_q[r][c] <= '0;
            for (int i = 0; i < INPUT_DIM; i++) begin
                x_q[i]    <= '0;
                ierr_q[i] <= '0;
            end
            for (int j = 0; j < OUTPUT_DIM; j++) e_q[j] <= '0;
        end else begin
            state_q <= state_d;
            tr_q    <= tr_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            x_q     <= x_d;
            e_q     <= e_d;
            ierr_q  <= ierr_d;
        end
    end

endmodule

// File: tb/tb_fc_layer_trainer.sv
// Scoreboarded bench for fc_layer_trainer: directed test-plan cases plus randomized samples against a fixed-point reference model.
module tb_fc_layer_trainer;

    localparam int          W  = 32;
    localparam int          ID = 4;
    localparam int          OD = 2;
    localparam int          CW = 8;
    localparam logic [31:0] LR = 32'h0000_1000;

    typedef logic [ID-1:0][W-1:0] ivec_t;
    typedef logic [OD-1:0][W-1:0] ovec_t;

    logic        clk, rst;
    logic        in_valid, in_ready, train_en;
    ivec_t       in_data;
    logic        out_valid, out_ready;
    ovec_t       out_data;
    logic        err_valid, err_ready;
    ovec_t       err_data;
    logic        ierr_valid, ierr_ready;
    ivec_t       ierr_data;
    logic        wl_valid, wl_ready;
    logic [2:0]  wl_row;
    logic [0:0]  wl_col;
    logic [W-1:0] wl_data;
    logic        busy;
    logic [CW-1:0] sample_count;

    fc_layer_trainer #(
        .WIDTH(W), .INPUT_DIM(ID), .OUTPUT_DIM(OD), .LEARNING_RATE(LR),
        .FIXED_POINT_INDEX(16), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .train_en(train_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
        .ierr_valid(ierr_valid), .ierr_ready(ierr_ready), .ierr_data(ierr_data),
        .wl_valid(wl_valid), .wl_ready(wl_ready), .wl_row(wl_row), .wl_col(wl_col), .wl_data(wl_data),
        .busy(busy), .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0]   mw [ID+1][OD];
    logic [CW-1:0] m_cnt;
    ovec_t         exp_out[$];
    ivec_t         exp_ierr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Q16.16 multiply: exact 64-bit product, floor-shifted back to the grid, wrapped to 32 bits.
    function automatic logic [31:0] fxm(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[47:16];
    endfunction

    function automatic ovec_t m_fwd(input ivec_t x);
        ovec_t r;
        for (int j = 0; j < OD; j++) begin
            r[j] = mw[0][j];
            for (int i = 0; i < ID; i++) r[j] = r[j] + fxm(x[i], mw[i+1][j]);
        end
        return r;
    endfunction

    task automatic m_train(input ivec_t x, input ovec_t e);
        ivec_t ie;
        for (int i = 0; i < ID; i++) begin
            ie[i] = '0;
            for (int j = 0; j < OD; j++) ie[i] = ie[i] + fxm(mw[i+1][j], e[j]);
        end
        exp_ierr.push_back(ie);
        for (int j = 0; j < OD; j++) begin
            mw[0][j] = mw[0][j] + fxm(LR, e[j]);
            for (int i = 0; i < ID; i++) mw[i+1][j] = mw[i+1][j] + fxm(LR, fxm(x[i], e[j]));
        end
    endtask

    task automatic m_clear();
        for (int r = 0; r <= ID; r++)
            for (int c = 0; c < OD; c++) mw[r][c] = '0;
        m_cnt = '0;
        exp_out.delete();
        exp_ierr.delete();
    endtask

    // Monitor: whenever a valid is up, its data must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    for (int j = 0; j < OD; j++) chk($sformatf("out_data[%0d]", j), out_data[j], exp_out[0][j]);
                    if (out_ready) void'(exp_out.pop_front());
                end
            end
            if (ierr_valid) begin
                if (exp_ierr.size() == 0) chk("ierr_unexpected", 1, 0);
                else begin
                    for (int i = 0; i < ID; i++) chk($sformatf("ierr_data[%0d]", i), ierr_data[i], exp_ierr[0][i]);
                    if (ierr_ready) void'(exp_ierr.pop_front());
                end
            end
        end
    end

    task automatic wload(input logic [2:0] row, input logic [0:0] col, input logic [31:0] d);
        wl_valid = 1'b1; wl_row = row; wl_col = col; wl_data = d;
        @(posedge clk); #1;
        wl_valid = 1'b0;
        if (row <= 3'(ID)) mw[row][col] = d;
    endtask

    task automatic do_sample(input ivec_t x, input bit tr, input ovec_t e,
                             input int os, input int ed, input int is);
        bit hs;
        int budget;
        exp_out.push_back(m_fwd(x));
        in_valid = 1'b1; in_data = x; train_en = tr;
        hs = 1'b0; budget = 0;
        while (!hs && budget < 20) begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1; budget++;
        end
        in_valid = 1'b0; train_en = 1'b0;
        if (!hs) begin
            chk("in_accept_timeout", 0, 1);
            return;
        end
        chk("out_valid_lat1", out_valid, 1);
        chk("in_ready_fwd", in_ready, 0);
        for (int k = 0; k < os; k++) begin
            @(posedge clk); #1;
            chk("out_valid_held", out_valid, 1);
            chk("in_ready_held", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (tr) begin
            chk("err_ready", err_ready, 1);
            chk("out_valid_drop", out_valid, 0);
            for (int k = 0; k < ed; k++) begin
                @(posedge clk); #1;
                chk("err_ready_wait", err_ready, 1);
            end
            m_train(x, e);
            err_valid = 1'b1; err_data = e;
            @(posedge clk); #1;
            err_valid = 1'b0;
            chk("ierr_valid_update", ierr_valid, 0);
            @(posedge clk); #1;
            chk("ierr_valid_lat2", ierr_valid, 1);
            for (int k = 0; k < is; k++) begin
                @(posedge clk); #1;
                chk("ierr_valid_held", ierr_valid, 1);
                chk("in_ready_bwd", in_ready, 0);
            end
            ierr_ready = 1'b1;
            @(posedge clk); #1;
            ierr_ready = 1'b0;
        end
        m_cnt++;
        chk("busy_idle", busy, 0);
        chk("sample_count", sample_count, m_cnt);
    endtask

    function automatic ivec_t rand_ivec();
        ivec_t v;
        for (int i = 0; i < ID; i++) v[i] = $urandom();
        return v;
    endfunction

    function automatic ovec_t rand_ovec();
        ovec_t v;
        for (int j = 0; j < OD; j++) v[j] = $urandom();
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ivec_t x;
        ovec_t e;
        logic [31:0] d;
        logic [2:0]  r;
        rst = 1'b1;
        in_valid = 0; in_data = '0; train_en = 0; out_ready = 0;
        err_valid = 0; err_data = '0; ierr_ready = 0;
        wl_valid = 0; wl_row = '0; wl_col = '0; wl_data = '0;
        m_clear();
        #22;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wl_ready", wl_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_ready", err_ready, 0);
        chk("rst_ierr_valid", ierr_valid, 0);

        // Zero weights: all-ones input infers zero.
        for (int i = 0; i < ID; i++) x[i] = 32'h0001_0000;
        do_sample(x, 1'b0, '0, 0, 0, 0);

        // Bias row {0.5, 0}, W[1][0] = 2.0.
        wload(3'd0, 1'b0, 32'h0000_8000);
        wload(3'd0, 1'b1, 32'h0000_0000);
        wload(3'd1, 1'b0, 32'h0002_0000);
        x = '0; x[0] = 32'h0001_0000;
        do_sample(x, 1'b0, '0, 0, 0, 0);

        // Train with err {1.0, 0}, stalling both output handshakes; then re-infer to observe the new W.
        e = '0; e[0] = 32'h0001_0000;
        do_sample(x, 1'b1, e, 5, 0, 3);
        do_sample(x, 1'b0, '0, 0, 0, 0);

        // Weight load and sample offered together: load wins, sample waits a cycle.
        x = rand_ivec();
        d = $urandom();
        wl_valid = 1'b1; wl_row = 3'd2; wl_col = 1'b1; wl_data = d;
        in_valid = 1'b1; in_data = x; train_en = 1'b0;
        #1;
        chk("collide_in_ready", in_ready, 0);
        chk("collide_wl_ready", wl_ready, 1);
        mw[2][1] = d;
        @(posedge clk); #1;
        wl_valid = 1'b0;
        chk("collide_not_taken", busy, 0);
        do_sample(x, 1'b0, '0, 0, 0, 0);

        // Randomized mix of loads (some out of range), inference and training with random stalls.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = 3'($urandom_range(0, 7));
                wload(r, 1'($urandom_range(0, 1)), $urandom());
            end
            do_sample(rand_ivec(), 1'($urandom_range(0, 1)), rand_ovec(),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset during WAIT_ERR aborts the sample and clears everything.
        wload(3'd1, 1'b1, 32'h0003_0000);
        x = rand_ivec();
        exp_out.push_back(m_fwd(x));
        in_valid = 1'b1; in_data = x; train_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; train_en = 1'b0;
        chk("abort_out_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("abort_in_wait_err", err_ready, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_err_ready", err_ready, 0);
        chk("abort_out_valid_low", out_valid, 0);
        chk("abort_ierr_valid", ierr_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_count", sample_count, 0);
        m_clear();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_sample(rand_ivec(), 1'b0, '0, 0, 0, 0);

        // Counter wrap: fill to all-ones, one more returns to 0.
        for (int r2 = 0; r2 <= ID; r2++) wload(3'(r2), 1'($urandom_range(0, 1)), $urandom());
        while (m_cnt != '1) do_sample(rand_ivec(), 1'b0, '0, 0, 0, 0);
        chk("count_full", sample_count, 8'hFF);
        do_sample(rand_ivec(), 1'b0, '0, 0, 0, 0);
        chk("count_wrap", sample_count, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("out_queue_drained", exp_out.size(), 0);
        chk("ierr_queue_drained", exp_ierr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
